// File: rtl/ace_tape_encoder_if.sv
`default_nettype none
// ============================================================================
// Module      : ace_tape_encoder_if
// Description : Byte-stream handshake between the save logic/FIFO (master)
//               and the Jupiter Ace tape-out encoder (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface ace_tape_encoder_if;
    logic [7:0] byte_data;
    logic       byte_last;
    logic       byte_valid;
    logic       byte_ready;

    modport master (
        output byte_data,
        output byte_last,
        output byte_valid,
        input  byte_ready
    );

    modport slave (
        input  byte_data,
        input  byte_last,
        input  byte_valid,
        output byte_ready
    );
endinterface
`default_nettype wire

// File: rtl/ace_tape_encoder.sv
`default_nettype none
// ============================================================================
// Module      : ace_tape_encoder
// Description : Jupiter Ace tape-out encoder. Turns a byte stream into a
//               1-bit tape waveform: leader tone, sync pulse, MSB-first
//               pulse-width-coded data bits and an end mark. All timing is
//               counted in ce (T-state enable) ticks.
// Revision    : 1.0 - initial release
// ============================================================================
module ace_tape_encoder #(
    parameter int LEADER_HALF   = 2011,
    parameter int LEADER_CYCLES = 4096,
    parameter int SYNC_HI       = 601,
    parameter int SYNC_LO       = 791,
    parameter int BIT0_HALF     = 795,
    parameter int BIT1_HALF     = 1585,
    parameter int END_HALF      = 903,
    parameter int CNT_W         = 12
) (
    input  wire logic           clk_sys,
    input  wire logic           reset_n,
    input  wire logic           ce,
    input  wire logic           start,
    ace_tape_encoder_if.slave   byte_if,
    output logic                tape_out,
    output logic                busy,
    output logic                done,
    output logic                underrun
);

    // Leader cycle counter must hold LEADER_CYCLES itself without wrapping.
    localparam int CYC_W = $clog2(LEADER_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEADER = 3'd1,
        S_SYNC   = 3'd2,
        S_FETCH  = 3'd3,
        S_BIT    = 3'd4,
        S_END    = 3'd5
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;        // remaining ce ticks in the current half
    logic [CYC_W-1:0]   cyc;        // remaining leader cycles
    logic               low_half;   // 0: high half of a pulse, 1: low half
    logic [7:0]         shift;      // byte being sent, MSB is the current bit
    logic [3:0]         bit_cnt;    // bits left in the current byte
    logic               last_r;     // current byte closes the block

    // Half-period length for a data bit value.
    function automatic logic [CNT_W-1:0] bit_half(input logic b);
        return b ? CNT_W'(BIT1_HALF) : CNT_W'(BIT0_HALF);
    endfunction

    // True on a ce tick that finishes the current half.
    logic half_end;
    assign half_end = ce && (cnt == CNT_W'(1));

    // The encoder only ever asks for data while parked in FETCH.
    assign byte_if.byte_ready = (state == S_FETCH);
    assign underrun           = (state == S_FETCH) && !byte_if.byte_valid;

    // Main sequencer: half-period engine plus block framing, registered outputs.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            cyc      <= '0;
            low_half <= 1'b0;
            shift    <= '0;
            bit_cnt  <= '0;
            last_r   <= 1'b0;
            tape_out <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    tape_out <= 1'b0;
                    if (start) begin
                        state    <= S_LEADER;
                        cnt      <= CNT_W'(LEADER_HALF);
                        cyc      <= CYC_W'(LEADER_CYCLES);
                        low_half <= 1'b0;
                        tape_out <= 1'b1;
                        busy     <= 1'b1;
                    end
                end

                S_LEADER: begin
                    if (half_end) begin
                        if (!low_half) begin
                            low_half <= 1'b1;
                            cnt      <= CNT_W'(LEADER_HALF);
                            tape_out <= 1'b0;
                        end else begin
                            // A full leader cycle just completed.
                            low_half <= 1'b0;
                            tape_out <= 1'b1;
                            cyc      <= cyc - CYC_W'(1);
                            if (cyc == CYC_W'(1)) begin
                                state <= S_SYNC;
                                cnt   <= CNT_W'(SYNC_HI);
                            end else begin
                                cnt   <= CNT_W'(LEADER_HALF);
                            end
                        end
                    end else if (ce) begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                S_SYNC: begin
                    if (half_end) begin
                        if (!low_half) begin
                            low_half <= 1'b1;
                            cnt      <= CNT_W'(SYNC_LO);
                            tape_out <= 1'b0;
                        end else begin
                            low_half <= 1'b0;
                            cnt      <= '0;
                            tape_out <= 1'b0;
                            state    <= S_FETCH;
                        end
                    end else if (ce) begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                S_FETCH: begin
                    // Handshake is not ce-gated so a waiting byte costs one clk_sys cycle.
                    tape_out <= 1'b0;
                    if (byte_if.byte_valid) begin
                        shift    <= byte_if.byte_data;
                        last_r   <= byte_if.byte_last;
                        bit_cnt  <= 4'd8;
                        low_half <= 1'b0;
                        cnt      <= bit_half(byte_if.byte_data[7]);
                        tape_out <= 1'b1;
                        state    <= S_BIT;
                    end
                end

                S_BIT: begin
                    if (half_end) begin
                        if (!low_half) begin
                            // Low half repeats the width of the high half.
                            low_half <= 1'b1;
                            cnt      <= bit_half(shift[7]);
                            tape_out <= 1'b0;
                        end else begin
                            low_half <= 1'b0;
                            shift    <= {shift[6:0], 1'b0};
                            bit_cnt  <= bit_cnt - 4'd1;
                            if (bit_cnt == 4'd1) begin
                                if (last_r) begin
                                    state    <= S_END;
                                    cnt      <= CNT_W'(END_HALF);
                                    tape_out <= 1'b1;
                                end else begin
                                    state    <= S_FETCH;
                                    cnt      <= '0;
                                    tape_out <= 1'b0;
                                end
                            end else begin
                                // Next bit is shift[6] before the shift lands.
                                cnt      <= bit_half(shift[6]);
                                tape_out <= 1'b1;
                            end
                        end
                    end else if (ce) begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                S_END: begin
                    if (half_end) begin
                        state    <= S_IDLE;
                        cnt      <= '0;
                        tape_out <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end else if (ce) begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    cnt      <= '0;
                    low_half <= 1'b0;
                    tape_out <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ace_tape_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ace_tape_encoder
// Description : Scoreboard bench for ace_tape_encoder with small timing
//               parameters. Expected tape halves are queued by the stimulus;
//               a monitor run-length-encodes tape_out in ce ticks (FETCH
//               cycles excluded) and compares each completed half.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ace_tape_encoder;

    localparam int LH = 4;
    localparam int LC = 2;
    localparam int SH = 2;
    localparam int SL = 3;
    localparam int B0 = 2;
    localparam int B1 = 3;
    localparam int EH = 5;
    localparam int TMO = 20000;

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    logic ce      = 1'b1;
    logic start   = 1'b0;
    logic tape_out, busy, done, underrun;

    ace_tape_encoder_if bif();

    ace_tape_encoder #(
        .LEADER_HALF   (LH),
        .LEADER_CYCLES (LC),
        .SYNC_HI       (SH),
        .SYNC_LO       (SL),
        .BIT0_HALF     (B0),
        .BIT1_HALF     (B1),
        .END_HALF      (EH),
        .CNT_W         (12)
    ) u_dut (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .ce       (ce),
        .start    (start),
        .byte_if  (bif),
        .tape_out (tape_out),
        .busy     (busy),
        .done     (done),
        .underrun (underrun)
    );

    always #5 clk_sys = ~clk_sys;

    // ce: every cycle, or one cycle in ce_div
    int ce_div = 1;
    int ce_ph  = 0;
    initial begin
        forever begin
            @(posedge clk_sys);
            #1;
            ce_ph = (ce_ph + 1 >= ce_div) ? 0 : ce_ph + 1;
            ce    = (ce_div == 1) ? 1'b1 : (ce_ph == 0);
        end
    end

    typedef struct packed {
        logic is_done;
        logic level;
        int   len;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic chk(input string name, input int got, input int req);
        vectors++;
        if (got !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic push_half(input logic lvl, input int len);
        exp_t e;
        e.is_done = 1'b0;
        e.level   = lvl;
        e.len     = len;
        exp_q.push_back(e);
    endtask

    task automatic push_done();
        exp_t e;
        e.is_done = 1'b1;
        e.level   = 1'b0;
        e.len     = 0;
        exp_q.push_back(e);
    endtask

    // Monitor side: compare one observed item against the queue head
    task automatic compare_item(input logic is_d, input logic lvl, input int len);
        exp_t e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_%s: got level=%0d len=%0d, required nothing",
                     is_d ? "done" : "half", lvl, len);
            return;
        end
        e = exp_q.pop_front();
        if (e.is_done !== is_d || e.level !== lvl || e.len !== len) begin
            miscompares++;
            $display("FAIL waveform: got done=%0d level=%0d len=%0d, required done=%0d level=%0d len=%0d",
                     is_d, lvl, len, e.is_done, e.level, e.len);
        end
    endtask

    logic in_run = 1'b0;
    logic run_level = 1'b0;
    int   run_ticks = 0;
    logic prev_busy = 1'b0;
    logic prev_tape = 1'b0;
    int   cyc_count = 0;
    int   fetch_cycles = 0;
    int   underrun_cycles = 0;
    int   done_count = 0;
    logic done_seen = 1'b0;
    int   rise_t[$];

    initial begin
        forever begin
            @(negedge clk_sys);
            cyc_count++;
            if (!reset_n) begin
                in_run    = 1'b0;
                prev_busy = 1'b0;
                prev_tape = 1'b0;
            end else begin
                if (busy && ce && !bif.byte_ready) begin
                    if (in_run && tape_out == run_level) begin
                        run_ticks++;
                    end else begin
                        if (in_run) compare_item(1'b0, run_level, run_ticks);
                        in_run    = 1'b1;
                        run_level = tape_out;
                        run_ticks = 1;
                    end
                end
                if (!busy && prev_busy && in_run) begin
                    compare_item(1'b0, run_level, run_ticks);
                    in_run = 1'b0;
                end
                if (done) begin
                    compare_item(1'b1, 1'b0, 0);
                    done_seen = 1'b1;
                    done_count++;
                end
                if (bif.byte_ready) begin
                    fetch_cycles++;
                    if (underrun) underrun_cycles++;
                    chk("fetch_tape_low", int'(tape_out), 0);
                end
                if (tape_out && !prev_tape) rise_t.push_back(cyc_count);
                prev_busy = busy;
                prev_tape = tape_out;
            end
        end
    end

    // Stimulus side
    logic [7:0] bq[4];

    // Hand-computed T2 waveform for 0xA5, alternating levels starting high
    int t2_len[23] = '{4,4,4,4, 2,3, 3,3, 2,2, 3,3, 2,2, 2,2, 3,3, 2,2, 3,3, 5};

    task automatic expect_table_a5();
        for (int i = 0; i < 23; i++) push_half((i % 2) == 0, t2_len[i]);
        push_done();
    endtask

    task automatic expect_block(input int n);
        for (int c = 0; c < LC; c++) begin
            push_half(1'b1, LH);
            push_half(1'b0, LH);
        end
        push_half(1'b1, SH);
        push_half(1'b0, SL);
        for (int i = 0; i < n; i++) begin
            for (int b = 7; b >= 0; b--) begin
                push_half(1'b1, bq[i][b] ? B1 : B0);
                push_half(1'b0, bq[i][b] ? B1 : B0);
            end
        end
        push_half(1'b1, EH);
        push_done();
    endtask

    task automatic drive_bytes(input int n, input int gap);
        int k;
        for (int i = 0; i < n; i++) begin
            bif.byte_data = bq[i];
            bif.byte_last = (i == n - 1);
            if (i == 0 && gap > 0) begin
                bif.byte_valid = 1'b0;
                k = 0;
                for (int t = 0; t < TMO && k < gap; t++) begin
                    @(negedge clk_sys);
                    if (bif.byte_ready) k++;
                end
                @(posedge clk_sys);
                #1;
            end
            bif.byte_valid = 1'b1;
            for (int t = 0; t < TMO; t++) begin
                @(negedge clk_sys);
                if (bif.byte_ready) break;
            end
            @(posedge clk_sys);
            #1;
        end
        bif.byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk_sys);
        #1 start = 1'b1;
        @(posedge clk_sys);
        #1 start = 1'b0;
    endtask

    task automatic run_block(input string name, input int n, input int gap,
                             input bit use_table, input bit mid_start);
        done_seen       = 1'b0;
        fetch_cycles    = 0;
        underrun_cycles = 0;
        rise_t.delete();
        if (use_table) expect_table_a5();
        else           expect_block(n);
        fork
            drive_bytes(n, gap);
            begin
                pulse_start();
                if (mid_start) begin
                    repeat (5) @(posedge clk_sys);
                    pulse_start();
                    repeat (20) @(posedge clk_sys);
                    pulse_start();
                end
            end
            begin
                for (int t = 0; t < TMO && !done_seen; t++) @(posedge clk_sys);
            end
        join
        chk({name, "_done_seen"}, int'(done_seen), 1);
        @(negedge clk_sys);
        chk({name, "_busy_after"}, int'(busy), 0);
        chk({name, "_tape_after"}, int'(tape_out), 0);
        chk({name, "_queue_left"}, exp_q.size(), 0);
        chk({name, "_fetch_cycles"}, fetch_cycles, n + gap);
        chk({name, "_underrun_cycles"}, underrun_cycles, gap);
        exp_q.delete();
        repeat (3) @(posedge clk_sys);
    endtask

    initial begin
        int dc;
        bif.byte_data  = 8'h00;
        bif.byte_last  = 1'b0;
        bif.byte_valid = 1'b0;

        // Power-on reset state
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        chk("rst_tape", int'(tape_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_underrun", int'(underrun), 0);
        chk("rst_ready", int'(bif.byte_ready), 0);
        #2 reset_n = 1'b1;
        repeat (2) @(posedge clk_sys);

        // T2: single byte 0xA5
        bq[0] = 8'hA5;
        run_block("t2", 1, 0, 1'b1, 1'b0);

        // T3: 0x00 then 0xFF back to back
        bq[0] = 8'h00;
        bq[1] = 8'hFF;
        run_block("t3", 2, 0, 1'b0, 1'b0);

        // T4: 7-cycle underrun then 0x80
        bq[0] = 8'h80;
        run_block("t4", 1, 7, 1'b0, 1'b0);

        // T5: start pulses while busy are ignored
        bq[0] = 8'hA5;
        run_block("t5", 1, 0, 1'b1, 1'b1);

        // T6: ce every third cycle
        ce_div = 3;
        bq[0] = 8'hA5;
        run_block("t6", 1, 0, 1'b0, 1'b0);
        vectors++;
        if (rise_t.size() < 3) begin
            miscompares++;
            $display("FAIL t6_rises: got %0d rising edges, required at least 3", rise_t.size());
        end else begin
            vectors--;
            chk("t6_leader_period_clks", rise_t[2] - rise_t[1], 2 * LH * 3);
        end
        ce_div = 1;
        repeat (4) @(posedge clk_sys);

        // T1: reset mid-BIT aborts immediately
        bq[0] = 8'hA5;
        fetch_cycles = 0;
        dc = done_count;
        expect_table_a5();
        fork
            drive_bytes(1, 0);
            begin
                pulse_start();
                for (int t = 0; t < TMO && fetch_cycles == 0; t++) @(posedge clk_sys);
                repeat (2) @(posedge clk_sys);
                #3;
                chk("t1_pre_reset_tape", int'(tape_out), 1);
                reset_n = 1'b0;
                #1;
                chk("t1_reset_tape", int'(tape_out), 0);
                chk("t1_reset_busy", int'(busy), 0);
                chk("t1_reset_ready", int'(bif.byte_ready), 0);
            end
        join
        exp_q.delete();
        repeat (2) @(posedge clk_sys);
        #2 reset_n = 1'b1;
        repeat (12) @(posedge clk_sys);
        @(negedge clk_sys);
        chk("t1_no_done", done_count - dc, 0);
        chk("t1_idle_busy", int'(busy), 0);
        chk("t1_idle_tape", int'(tape_out), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
